// File: rtl/spi_slave_rx_if.sv
// SPI slave receiver bundle: SPI pins plus local reply/receive bus.
// The slave modport is the receiver's view, master is the driver side.
interface spi_slave_rx_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  sclk;
    logic                  cs;
    logic                  mosi;
    logic                  miso;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_load;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  frame_error;
    logic                  busy;

    modport slave (
        input  sclk, cs, mosi, tx_data, tx_load,
        output miso, rx_data, rx_valid, frame_error, busy
    );

    modport master (
        output sclk, cs, mosi, tx_data, tx_load,
        input  miso, rx_data, rx_valid, frame_error, busy
    );
endinterface

// File: rtl/spi_slave_rx.sv
// Mode-0 SPI slave: oversamples sclk/cs/mosi on the system clock,
// assembles MSB-first frames and shifts a preloaded reply out on miso.
module spi_slave_rx #(
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          reset,
    spi_slave_rx_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        WAIT_CS
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   cs_prev_q, cs_prev_d;

    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  done_q, done_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  ferr_q, ferr_d;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic last_bit;

    // Pin synchronisers plus one extra stage on sclk/cs for edge strobes.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], bus.cs};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
        sclk_s      = sclk_sync_q[SYNC_STAGES-1];
        cs_s        = cs_sync_q[SYNC_STAGES-1];
        mosi_s      = mosi_sync_q[SYNC_STAGES-1];
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
        sclk_rise   = sclk_s & ~sclk_prev_q;
        sclk_fall   = ~sclk_s & sclk_prev_q;
        cs_rise     = cs_s & ~cs_prev_q;
        cs_fall     = ~cs_s & cs_prev_q;
    end

    assign last_bit = (bit_cnt_q == CNT_W'(DATA_WIDTH - 1));

    // Frame FSM: next state, shift registers and output pulses.
    always_comb begin
        state_d    = state_q;
        hold_d     = bus.tx_load ? bus.tx_data : hold_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        bit_cnt_d  = bit_cnt_q;
        done_d     = 1'b0;
        rx_valid_d = done_q;
        rx_data_d  = done_q ? rx_shift_q : rx_data_q;
        ferr_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    tx_shift_d = hold_q;
                    bit_cnt_d  = '0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (sclk_fall) begin
                    tx_shift_d = tx_shift_q << 1;
                end
                if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                end
                // A completing rise wins over a simultaneous cs rise.
                if (sclk_rise && last_bit) begin
                    done_d  = 1'b1;
                    state_d = cs_rise ? IDLE : WAIT_CS;
                end else if (cs_rise) begin
                    ferr_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT_CS: begin
                if (sclk_rise) begin
                    ferr_d = 1'b1;
                end
                if (cs_rise) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, all cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
            hold_q      <= '0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            bit_cnt_q   <= '0;
            done_q      <= 1'b0;
            rx_valid_q  <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            hold_q      <= hold_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            bit_cnt_q   <= bit_cnt_d;
            done_q      <= done_d;
            rx_valid_q  <= rx_valid_d;
            ferr_q      <= ferr_d;
        end
    end

    assign bus.miso        = (state_q != IDLE && !cs_s) ?
                             tx_shift_q[DATA_WIDTH-1] : 1'b0;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.frame_error = ferr_q;
    assign bus.busy        = (state_q != IDLE);
endmodule
